// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler: latches per-source activity strobes and shows one pending
// source at a time on a single LED as (index+1) blinks followed by a gap.
module led_blink_scheduler #(
    parameter int N_SRC   = 4,
    parameter int ON_LEN  = 1 << 22,
    parameter int OFF_LEN = 1 << 22,
    parameter int GAP_LEN = 1 << 24,
    localparam int SW     = $clog2(N_SRC > 1 ? N_SRC : 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    output logic             led,
    output logic             busy,
    output logic [SW-1:0]    cur_src
);
    localparam int MAXL = ON_LEN > OFF_LEN ? (ON_LEN > GAP_LEN ? ON_LEN : GAP_LEN)
                                           : (OFF_LEN > GAP_LEN ? OFF_LEN : GAP_LEN);
    localparam int CW   = $clog2(MAXL) + 1;
    localparam int SW1  = SW + 1;

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [4:0]         blinks, blinks_n;
    logic [SW-1:0]      last_grant, last_n, cur_n, grant, idx;
    logic [SW1-1:0]     sum;
    logic [N_SRC-1:0]   s0, s1, s2, prev, pending, pending_n, clr;
    logic               found;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0         <= '0;
            s1         <= '0;
            s2         <= '0;
            prev       <= '0;
            pending    <= '0;
            state      <= IDLE;
            cnt        <= '0;
            blinks     <= '0;
            last_grant <= SW'(N_SRC - 1);
            cur_src    <= '0;
        end else begin
            s0         <= req;
            s1         <= s0;
            s2         <= s1;
            prev       <= s2;
            pending    <= pending_n;
            state      <= state_n;
            cnt        <= cnt_n;
            blinks     <= blinks_n;
            last_grant <= last_n;
            cur_src    <= cur_n;
        end
    end

    // Round-robin search starting just after the previously shown source
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            sum = {1'b0, last_grant} + SW1'(i);
            idx = sum >= SW1'(N_SRC) ? SW'(sum - SW1'(N_SRC)) : SW'(sum);
            if (!found && pending[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt - 1'b1;
        blinks_n = blinks;
        last_n   = last_grant;
        cur_n    = cur_src;
        clr      = '0;
        case (state)
            IDLE: if (found) begin
                state_n    = ON;
                cnt_n      = CW'(ON_LEN - 1);
                blinks_n   = 5'(grant) + 5'd1;
                last_n     = grant;
                cur_n      = grant;
                clr[grant] = 1'b1;
            end
            ON: if (cnt == '0) begin
                state_n  = OFF;
                cnt_n    = CW'(OFF_LEN - 1);
                blinks_n = blinks - 5'd1;
            end
            OFF: if (cnt == '0) begin
                state_n = blinks != '0 ? ON : GAP;
                cnt_n   = blinks != '0 ? CW'(ON_LEN - 1) : CW'(GAP_LEN - 1);
            end
            GAP: if (cnt == '0) state_n = IDLE;
        endcase
        // A new edge in the same cycle as the grant keeps the request pending
        pending_n = (pending & ~clr) | (s2 & ~prev);
    end

    assign led  = state == ON;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_led_blink_scheduler.sv
// tb_led_blink_scheduler: directed stimulus with a queue of expected blink codes
// checked by an independent monitor that measures each code on the LED.
module tb_led_blink_scheduler;
    typedef struct {
        int src;
        bit aborted;
        int gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       led, busy;
    logic [1:0] cur_src;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   fails  = 0;

    led_blink_scheduler #(.N_SRC(4), .ON_LEN(4), .OFF_LEN(3), .GAP_LEN(10)) dut (
        .clk(clk), .rst(rst), .req(req), .led(led), .busy(busy), .cur_src(cur_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] mask);
        req = req | mask;
        tick(1);
        req = req & ~mask;
    endtask

    task automatic wait_for(input bit use_led, input logic val, input string name);
        int n = 0;
        while ((use_led ? led : busy) !== val && n < 2000) begin
            tick(1);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            fails++;
            $display("FAIL %s: timeout waiting for %0b", name, val);
        end
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 20 && n < 3000) begin
            tick(1);
            quiet = busy ? 0 : quiet + 1;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            fails++;
            $display("FAIL %s: timeout waiting for idle", name);
        end
    endtask

    task automatic push(input int src, input bit aborted, input int gap);
        exp_q.push_back('{src: src, aborted: aborted, gap: gap});
    endtask

    // Monitor: measures every code between busy rising and falling
    bit in_code = 0, prev_led = 0, aborted = 0, src_moved = 0;
    int len, ons, blinks, code_src, gap_before;
    int idle_len = 0;

    always @(negedge clk) begin
        if (busy) begin
            if (!in_code) begin
                in_code    = 1;
                len        = 0;
                ons        = 0;
                blinks     = 0;
                prev_led   = 0;
                aborted    = 0;
                src_moved  = 0;
                code_src   = int'(cur_src);
                gap_before = idle_len;
            end
            len++;
            if (led) ons++;
            if (led && !prev_led) blinks++;
            prev_led = led;
            if (rst) aborted = 1;
            if (int'(cur_src) != code_src) src_moved = 1;
        end else begin
            if (in_code) begin
                in_code = 0;
                idle_len = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_code: got src %0d expected no code", code_src);
                end else begin
                    e = exp_q.pop_front();
                    chk("code_src", code_src, e.src);
                    chk("code_src_stable", int'(src_moved), 0);
                    chk("code_aborted", int'(aborted), int'(e.aborted));
                    if (!e.aborted) begin
                        chk("busy_len", len, (e.src + 1) * 7 + 10);
                        chk("blink_count", blinks, e.src + 1);
                        chk("led_on_cycles", ons, (e.src + 1) * 4);
                        if (e.gap >= 0) chk("idle_gap", gap_before, e.gap);
                    end
                end
            end
            idle_len++;
        end
    end

    initial begin
        int n;
        tick(3);
        chk("reset_led", int'(led), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_cur_src", int'(cur_src), 0);
        rst = 1'b0;
        tick(2);

        // Simultaneous src 0 and src 3: src 0 first after reset, one idle cycle between
        push(0, 0, -1);
        push(3, 0, 1);
        pulse(4'b1001);
        wait_idle("t2");

        // Single src 2 pulse, LED latency measured from the request
        push(2, 0, -1);
        req[2] = 1'b1;
        tick(1);
        req[2] = 1'b0;
        n = 1;
        while (!led && n < 20) begin
            tick(1);
            n++;
        end
        chk("led_latency", n, 5);
        chk("cur_src_t1", int'(cur_src), 2);
        wait_idle("t1");

        // src 1 and src 2 re-requested during codes: strict alternation
        push(1, 0, -1);
        for (int i = 0; i < 5; i++) begin
            push(2, 0, 1);
            if (i < 2) push(1, 0, 1);
        end
        while (exp_q.size() > 6) void'(exp_q.pop_back());
        pulse(4'b0110);
        for (int c = 0; c < 4; c++) begin
            wait_for(0, 1'b1, "t3_start");
            tick(2);
            pulse(4'b0110);
            wait_for(0, 1'b0, "t3_end");
        end
        wait_idle("t3");

        // Five re-requests from the active source coalesce into one more code
        push(1, 0, -1);
        push(1, 0, 1);
        pulse(4'b0010);
        wait_for(0, 1'b1, "t4_start");
        repeat (5) begin
            pulse(4'b0010);
            tick(2);
        end
        wait_idle("t4");

        // Reset during the second blink of src 3 drops pending src 0
        push(3, 1, -1);
        pulse(4'b1000);
        wait_for(0, 1'b1, "t5_start");
        tick(1);
        pulse(4'b0001);
        req[2] = 1'b1;
        wait_for(1, 1'b0, "t5_off");
        wait_for(1, 1'b1, "t5_on2");
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("rst_led", int'(led), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        push(2, 0, -1);
        tick(10);
        req[2] = 1'b0;
        wait_idle("t5");

        // Level held high gives one event; a fresh rising edge gives another
        push(1, 0, -1);
        req[1] = 1'b1;
        tick(200);
        req[1] = 1'b0;
        tick(5);
        push(1, 0, -1);
        req[1] = 1'b1;
        tick(5);
        req[1] = 1'b0;
        wait_idle("t6");

        tick(50);
        chk("codes_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/led_blink_scheduler.md
Name: led_blink_scheduler

Overview:
- Shares one status LED between N_SRC event sources, e.g. DMA done, NVMe command, error, heartbeat.
- Each source's activity strobe is latched as a pending request.
- A round-robin scheduler grants one pending source at a time. The granted source is shown as a blink code: (index+1) blinks, then an inter-code gap.
- Sits between status strobes from the datapath and the board LED pin. It replaces a plain per-source pulse lengthener when pins are scarce.

Parameters:
- N_SRC, 4, number of request sources; legal range 1..16.
- ON_LEN, 1<<22, LED-on cycles per blink; must be >= 1.
- OFF_LEN, 1<<22, LED-off cycles after each blink; must be >= 1.
- GAP_LEN, 1<<24, LED-off cycles after the last blink of a code; must be >= 1.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req  input  N_SRC  asynchronous activity strobes, one per source; any width >= 1 clk
- led  output  1  LED drive, 1 = lit
- busy  output  1  high while a code is being shown (states ON/OFF/GAP)
- cur_src  output  max(1,$clog2(N_SRC))  index of the source being shown; holds its last value in IDLE

Behaviour:
- Reset values: led=0, busy=0, cur_src=0, pending=0, sync/edge registers=0, state=IDLE, last_grant=N_SRC-1 (source 0 has first priority).
- Input synchronizer: per bit, 3 flops, all reset to 0.
- Edge detect: one register on the synchronizer output. A rising edge sets pending[i].
  - req[i] rising at cycle t (first sampled high) -> pending[i]=1 at t+4.
  - req[i] held high out of reset produces exactly one event.
- Pending coalescing: any number of edges before a grant yields one pending request.
  - If a set and a clear of pending[i] (grant) happen in the same cycle, set wins.
- Counter width: $clog2(max(ON_LEN,OFF_LEN,GAP_LEN))+1 bits. The blink counter is 5 bits.
- FSM states: IDLE, ON, OFF, GAP.
- IDLE:
  - If any pending, grant the first set bit searching from last_grant+1 upward with wrap to 0.
  - Next cycle: state=ON, led=1, busy=1, cur_src=grant, last_grant=grant, pending[grant] cleared, blinks_left=grant+1, cnt=ON_LEN-1.
  - If nothing is pending, stay in IDLE with led=0.
- ON: led=1. Count down. At cnt==0: go to OFF, cnt=OFF_LEN-1, blinks_left decremented.
- OFF: led=0. At cnt==0:
  - If blinks_left!=0: go to ON, cnt=ON_LEN-1.
  - Else: go to GAP, cnt=GAP_LEN-1.
- GAP: led=0. At cnt==0: go to IDLE. Arbitration takes place in the IDLE cycle.
- Each ON/OFF/GAP state lasts exactly its parameter length in cycles.
- Code for source k:
  - led rises 1 cycle after pending[k] is seen in IDLE (t+5 from req edge).
  - busy is high for (k+1)*(ON_LEN+OFF_LEN)+GAP_LEN cycles, then drops for at least 1 IDLE cycle between codes.
- Preemption: none. Requests arriving mid-code (including from the active source) only set pending.
- rst at any time:
  - Next cycle: led=0, busy=0, all pending discarded, state=IDLE, last_grant=N_SRC-1.
  - The sync chain restarts from 0.
- N_SRC=1: the arbiter degenerates; source 0 always shows 1 blink.

Test Plan:
Parameters for all scenarios: N_SRC=4, ON_LEN=4, OFF_LEN=3, GAP_LEN=10.
1. Single 1-cycle req[2] pulse at cycle t:
   - led high at t+5 for 4 cycles, pattern 4 on/3 off repeated 3 times, then 10 off.
   - busy high 31 cycles; cur_src=2; then IDLE.
2. req[0] and req[3] pulsed in the same cycle:
   - src 0 code (1 blink, busy 17 cycles) first.
   - Then 1 IDLE cycle, then src 3 code (4 blinks, busy 38 cycles).
3. req[1] and req[2] re-pulsed during every code, 6 codes observed:
   - cur_src sequence 1,2,1,2,1,2; no source starved.
4. req[1] pulsed 5 times during its own code:
   - Exactly one additional src-1 code follows; nothing more.
5. rst asserted for 1 cycle during the 2nd ON phase of src 3:
   - Next cycle led=0, busy=0.
   - A pending req[0] set before reset is lost.
   - req[2] held high through reset produces exactly one src-2 code afterwards.
6. req[1] held high constantly for 200 cycles from IDLE:
   - Exactly one src-1 code.
   - Falling then rising again triggers one more.
